// File: rtl/cim_pkg.sv
// Shared definitions for the CIM read and write controllers: widths, FSM state codes,
// the latched request record and the chip-select decode.
package cim_pkg;

    localparam int CIM_N      = 4;
    localparam int CIM_DATA_W = 72;
    localparam int CIM_N_COL  = 16;
    localparam int OP_ADR_W   = 12;
    localparam int LINE_W     = CIM_N_COL * CIM_DATA_W;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SETUP      = 3'd1;
    localparam logic [2:0] ST_CS_ASSERT  = 3'd2;
    localparam logic [2:0] ST_CS_RELEASE = 3'd3;
    localparam logic [2:0] ST_WAIT_BUSY  = 3'd4;
    localparam logic [2:0] ST_CAPTURE    = 3'd5;
    localparam logic [2:0] ST_ADVANCE    = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

    typedef struct packed {
        logic [1:0] cim_sel;
        logic       bank_sel;
        logic [7:0] row;
    } cim_req_t;

    // Active-low one-hot chip select for the addressed macro.
    function automatic logic [CIM_N-1:0] cs_select_n(input logic [1:0] sel);
        return ~(CIM_N'(1) << sel);
    endfunction

endpackage

// File: rtl/cim_busy_wait.sv
// Selected-macro busy mux with a down-counting abort timer; shared by the CIM read and
// write controllers.
module cim_busy_wait import cim_pkg::*; #(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [CIM_N-1:0] cim_busy,
    input  logic [1:0]       sel,
    output logic             ready,
    output logic             timeout
);

    logic [7:0] cnt;
    logic       sel_busy;

    assign sel_busy = cim_busy[sel];
    assign ready    = ~sel_busy;
    // Loaded with TIMEOUT, so terminal count 1 marks the TIMEOUT-th busy cycle.
    assign timeout  = en & sel_busy & (cnt == 8'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'(TIMEOUT);
        end else if (en && sel_busy && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/cim_rd_ctr.sv
// CIM read-out controller: reads one row of a CIM across both banks (32 x 72-bit words)
// and streams the words into two output buffer lines.
//
// state      | meaning
// IDLE       | waiting for a read request
// SETUP      | clear chunk counter
// CS_ASSERT  | chip select low, op address/sel valid
// CS_RELEASE | chip select high, arm busy timer
// WAIT_BUSY  | wait for selected macro busy release
// CAPTURE    | buffer write strobe active
// ADVANCE    | next chunk or finish
// DONE       | one-cycle completion pulse
module cim_rd_ctr import cim_pkg::*; #(
    parameter int DATA_W  = CIM_DATA_W,
    parameter int N_COL   = CIM_N_COL,
    parameter int ADR_W   = 11,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rq_n,
    input  logic              i_rw_n,
    input  logic [1:0]        i_cim_sel,
    input  logic              i_bank_sel,
    input  logic [7:0]        i_row,
    input  logic [ADR_W-1:0]  i_outbuffer_adr,
    output logic              o_busy,
    input  logic [CIM_N-1:0]  i_cim_busy,
    input  logic [DATA_W-1:0] i_cim_rdata,
    output logic [CIM_N-1:0]  o_cim_cs_n,
    output logic [1:0]        o_op_sel,
    output logic [11:0]       o_op_adr,
    output logic              o_op_rw_n,
    output logic [3:0]        o_demux_sel,
    output logic [ADR_W-1:0]  o_outbuffer_adr,
    output logic              o_outbuffer_we,
    output logic [DATA_W-1:0] o_outbuffer_wdata,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [4:0] K_LAST = 5'(2 * N_COL - 1);

    logic [2:0]       state;
    logic [4:0]       k;
    logic [4:0]       k_nxt;
    cim_req_t         req_q;
    logic [ADR_W-1:0] base_q;
    logic             accept;
    logic             load_op;
    logic             bw_ready;
    logic             bw_timeout;

    assign accept  = (state == ST_IDLE) && !i_rq_n && i_rw_n;
    assign k_nxt   = (state == ST_ADVANCE) ? k + 5'd1 : 5'd0;
    // Operation fields are loaded on every edge that enters CS_ASSERT.
    assign load_op = (state == ST_SETUP) || (state == ST_ADVANCE && k != K_LAST);

    cim_busy_wait #(.TIMEOUT(TIMEOUT)) u_busy_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == ST_CS_RELEASE),
        .en       (state == ST_WAIT_BUSY),
        .cim_busy (i_cim_busy),
        .sel      (req_q.cim_sel),
        .ready    (bw_ready),
        .timeout  (bw_timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            k                 <= 5'd0;
            req_q             <= '0;
            base_q            <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_err             <= 1'b0;
            o_op_rw_n         <= 1'b1;
            o_outbuffer_we    <= 1'b0;
            o_outbuffer_wdata <= '0;
        end else begin
            o_outbuffer_we <= 1'b0;
            o_done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_q  <= '{cim_sel: i_cim_sel, bank_sel: i_bank_sel, row: i_row};
                        base_q <= i_outbuffer_adr;
                        o_busy <= 1'b1;
                        o_err  <= 1'b0;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    k         <= 5'd0;
                    o_op_rw_n <= 1'b1;
                    state     <= ST_CS_ASSERT;
                end
                ST_CS_ASSERT:  state <= ST_CS_RELEASE;
                ST_CS_RELEASE: state <= ST_WAIT_BUSY;
                ST_WAIT_BUSY: begin
                    if (bw_ready) begin
                        // Read data is valid while the macro reports not-busy.
                        o_outbuffer_wdata <= i_cim_rdata;
                        o_outbuffer_we    <= 1'b1;
                        state             <= ST_CAPTURE;
                    end else if (bw_timeout) begin
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_CAPTURE: state <= ST_ADVANCE;
                ST_ADVANCE: begin
                    if (k == K_LAST) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        k     <= k_nxt;
                        state <= ST_CS_ASSERT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_cim_cs_n      <= '1;
            o_op_sel        <= 2'b00;
            o_op_adr        <= 12'd0;
            o_demux_sel     <= 4'd0;
            o_outbuffer_adr <= '0;
        end else if (load_op) begin
            o_cim_cs_n      <= cs_select_n(req_q.cim_sel);
            o_op_adr        <= {req_q.row, k_nxt[3:0]};
            o_op_sel        <= {req_q.bank_sel, k_nxt[4]};
            o_demux_sel     <= k_nxt[3:0];
            o_outbuffer_adr <= base_q + {{(ADR_W-1){1'b0}}, k_nxt[4]};
        end else if (state == ST_CS_ASSERT) begin
            o_cim_cs_n <= '1;
        end
    end

endmodule

// File: tb/tb_cim_rd_ctr.sv
// Directed bench for cim_rd_ctr: a table of read transfers with hand-computed timing and
// addresses, plus sequences for timeout, mid-transfer reset and request filtering.
module tb_cim_rd_ctr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_rq_n, i_rw_n, i_bank_sel;
    logic [1:0]  i_cim_sel;
    logic [7:0]  i_row;
    logic [10:0] i_outbuffer_adr;
    logic        o_busy;
    logic [3:0]  i_cim_busy;
    logic [71:0] i_cim_rdata;
    logic [3:0]  o_cim_cs_n;
    logic [1:0]  o_op_sel;
    logic [11:0] o_op_adr;
    logic        o_op_rw_n;
    logic [3:0]  o_demux_sel;
    logic [10:0] o_outbuffer_adr;
    logic        o_outbuffer_we;
    logic [71:0] o_outbuffer_wdata;
    logic        o_done, o_err;

    cim_rd_ctr dut (
        .clk(clk), .rst_n(rst_n), .i_rq_n(i_rq_n), .i_rw_n(i_rw_n),
        .i_cim_sel(i_cim_sel), .i_bank_sel(i_bank_sel), .i_row(i_row),
        .i_outbuffer_adr(i_outbuffer_adr), .o_busy(o_busy), .i_cim_busy(i_cim_busy),
        .i_cim_rdata(i_cim_rdata), .o_cim_cs_n(o_cim_cs_n), .o_op_sel(o_op_sel),
        .o_op_adr(o_op_adr), .o_op_rw_n(o_op_rw_n), .o_demux_sel(o_demux_sel),
        .o_outbuffer_adr(o_outbuffer_adr), .o_outbuffer_we(o_outbuffer_we),
        .o_outbuffer_wdata(o_outbuffer_wdata), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cim_sel;
        logic        bank;
        logic [7:0]  row;
        logic [10:0] base;
        int          stall;
        bit          noise;
        bit          pulse;
        int          exp_done;
        logic [10:0] adr_lo;
        logic [10:0] adr_hi;
    } vec_t;

    vec_t vecs[5];
    int total = 0;
    int bad = 0;

    // environment / monitor state
    bit          mon_on = 0;
    bit          stick = 0;
    logic [1:0]  cur_sel;
    logic        cur_bank;
    logic [7:0]  cur_row;
    logic [10:0] cur_lo, cur_hi;
    int          cur_stall;
    bit          cur_noise;
    int chunk, wr_idx, busy_cnt, rel, done_rel, err_rel, done_cnt;
    int other_cs, opadr_bad, opsel_bad, adr_bad, demux_bad, wdata_bad, busy_bad;
    bit active, prev_cs, prev_busy, prev_err;

    function automatic logic [71:0] pat(input int idx);
        return {8'(idx * 7 + 3), 32'hC0DE0000 | 32'(idx), 32'h5A5A5A00 + 32'(idx)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic env_clear();
        chunk = 0; wr_idx = 0; busy_cnt = 0; rel = 0; done_rel = -1; err_rel = -1;
        done_cnt = 0; other_cs = 0; opadr_bad = 0; opsel_bad = 0; adr_bad = 0;
        demux_bad = 0; wdata_bad = 0; busy_bad = 0; active = 0; prev_cs = 1; prev_busy = 0;
    endtask

    always @(posedge clk) begin
        logic cs_s;
        logic sel_busy;
        #1;
        if (mon_on) begin
            cs_s = o_cim_cs_n[cur_sel];
            if (o_busy && !prev_busy) begin active = 1; rel = 0; end
            else rel = rel + 1;
            if (o_done) done_cnt++;
            if (active && o_done) begin
                done_rel = rel;
                if (o_busy) busy_bad++;
                active = 0;
            end else if (active && o_err && !prev_err) begin
                err_rel = rel;
                active = 0;
            end else if (active && !o_busy) begin
                busy_bad++;
            end
            if ((o_cim_cs_n | (4'b0001 << cur_sel)) != 4'hF) other_cs++;
            if (!cs_s && prev_cs) begin
                if (o_op_adr != {cur_row, 4'(chunk)}) opadr_bad++;
                if (o_op_sel != {cur_bank, chunk >= 16}) opsel_bad++;
                chunk++;
            end
            if (cs_s && !prev_cs) busy_cnt = cur_stall;
            else if (busy_cnt > 0) busy_cnt--;
            if (o_outbuffer_we) begin
                if (o_outbuffer_adr != ((wr_idx < 16) ? cur_lo : cur_hi)) adr_bad++;
                if (o_demux_sel != 4'(wr_idx)) demux_bad++;
                if (o_outbuffer_wdata != pat(wr_idx)) wdata_bad++;
                wr_idx++;
            end
            prev_cs = cs_s;
            sel_busy = (busy_cnt > 0) || (stick && chunk >= 5);
            i_cim_busy = cur_noise ? 4'($urandom) : 4'h0;
            i_cim_busy[cur_sel] = sel_busy;
            i_cim_rdata = (sel_busy || !cs_s) ? {8'($urandom), $urandom, $urandom}
                                               : pat(chunk - 1);
        end else begin
            i_cim_busy = 4'h0;
            i_cim_rdata = '0;
        end
        prev_busy = o_busy;
        prev_err = o_err;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_cs"}, 32'(o_cim_cs_n), 32'hF);
        chk({tag, "_rw"}, 32'(o_op_rw_n), 1);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done_err_we"}, {29'd0, o_done, o_err, o_outbuffer_we}, 0);
        chk({tag, "_opsel_adr"}, {18'd0, o_op_sel, o_op_adr}, 0);
        chk({tag, "_demux_obadr"}, {17'd0, o_demux_sel, o_outbuffer_adr}, 0);
        chk({tag, "_wdata_zero"}, 32'(o_outbuffer_wdata == 72'd0), 1);
    endtask

    task automatic start_req(input vec_t v);
        env_clear();
        cur_sel = v.cim_sel; cur_bank = v.bank; cur_row = v.row;
        cur_lo = v.adr_lo; cur_hi = v.adr_hi; cur_stall = v.stall; cur_noise = v.noise;
        mon_on = 1;
        @(posedge clk); #2;
        i_rq_n = 0; i_rw_n = 1;
        i_cim_sel = v.cim_sel; i_bank_sel = v.bank; i_row = v.row; i_outbuffer_adr = v.base;
        @(posedge clk); #2;
        i_rq_n = 1;
        chk("accept_busy", 32'(o_busy), 1);
        chk("accept_err_clr", 32'(o_err), 0);
    endtask

    task automatic wait_end(input bit pulse);
        bit seen = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #2;
            i_rq_n = 1;
            if (done_rel >= 0 || err_rel >= 0) begin seen = 1; break; end
            if (pulse && (n % 20) == 5) begin
                i_rq_n = 0; i_rw_n = 1;
                i_cim_sel = cur_sel ^ 2'd1; i_row = ~cur_row; i_outbuffer_adr = 11'h155;
            end
        end
        chk("end_seen", 32'(seen), 1);
    endtask

    task automatic run(input vec_t v);
        start_req(v);
        wait_end(v.pulse);
        repeat (3) @(posedge clk);
        #2;
        chk("done_edge", 32'(done_rel), 32'(v.exp_done));
        chk("done_cnt", 32'(done_cnt), 1);
        chk("cs_pulses", 32'(chunk), 32);
        chk("other_cs", 32'(other_cs), 0);
        chk("we_cnt", 32'(wr_idx), 32);
        chk("op_adr_bad", 32'(opadr_bad), 0);
        chk("op_sel_bad", 32'(opsel_bad), 0);
        chk("ob_adr_bad", 32'(adr_bad), 0);
        chk("demux_bad", 32'(demux_bad), 0);
        chk("wdata_bad", 32'(wdata_bad), 0);
        chk("busy_bad", 32'(busy_bad), 0);
        chk("err_low", 32'(o_err), 0);
        chk("idle_busy", 32'(o_busy), 0);
    endtask

    initial begin
        vec_t tv;
        int fbad;
        bit reached;
        // sel bank row base stall noise pulse done lo hi
        vecs[0] = '{2'd2, 1'b1, 8'h5A, 11'h010, 3, 0, 0, 225, 11'h010, 11'h011};
        vecs[1] = '{2'd0, 1'b0, 8'h00, 11'h123, 0, 0, 0, 161, 11'h123, 11'h124};
        vecs[2] = '{2'd0, 1'b1, 8'hFF, 11'h7FF, 0, 1, 0, 161, 11'h7FF, 11'h000};
        vecs[3] = '{2'd3, 1'b0, 8'h3C, 11'h400, 1, 0, 1, 161, 11'h400, 11'h401};
        vecs[4] = '{2'd1, 1'b1, 8'hA5, 11'h2FE, 2, 0, 0, 193, 11'h2FE, 11'h2FF};

        rst_n = 0; i_rq_n = 1; i_rw_n = 1; i_cim_sel = 0; i_bank_sel = 0;
        i_row = 0; i_outbuffer_adr = 0; i_cim_busy = 0; i_cim_rdata = 0;
        env_clear();
        repeat (3) @(posedge clk);
        #2;
        chk_reset("por");
        rst_n = 1;

        // write-type requests in IDLE must be ignored
        fbad = 0;
        i_rq_n = 0; i_rw_n = 0; i_cim_sel = 2'd1;
        repeat (6) begin
            @(posedge clk); #2;
            if (o_busy || o_cim_cs_n != 4'hF) fbad++;
        end
        i_rq_n = 1; i_rw_n = 1;
        chk("filter_rw", 32'(fbad), 0);
        chk("filter_opadr", 32'(o_op_adr), 0);

        for (int i = 0; i < 5; i++) run(vecs[i]);

        // busy stuck on CIM 1 from chunk 4: chunk 4 enters WAIT at edge 23, abort at 278
        tv = '{2'd1, 1'b0, 8'h11, 11'h050, 0, 0, 0, 0, 11'h050, 11'h051};
        stick = 1;
        start_req(tv);
        wait_end(0);
        chk("to_err_edge", 32'(err_rel), 278);
        chk("to_err", 32'(o_err), 1);
        chk("to_busy", 32'(o_busy), 0);
        chk("to_cs", 32'(o_cim_cs_n), 32'hF);
        repeat (5) @(posedge clk);
        #2;
        chk("to_we_cnt", 32'(wr_idx), 4);
        chk("to_no_done", 32'(done_cnt), 0);
        stick = 0;
        run(vecs[1]);

        // reset during chunk 7 WAIT_BUSY (period 6: WAIT entered at edge 45)
        tv = '{2'd3, 1'b1, 8'h77, 11'h200, 2, 0, 0, 0, 11'h200, 11'h201};
        start_req(tv);
        reached = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #2;
            if (rel == 45) begin reached = 1; break; end
        end
        chk("mid_reached", 32'(reached), 1);
        rst_n = 0;
        @(posedge clk); #2;
        chk_reset("midrst");
        rst_n = 1;
        run(vecs[0]);

        mon_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
